bus_pack: RTL and testbench

BUS_PACK -- requirements
Module: bus_pack

---
 rtl/bus_pack.sv | 76 +++++++
 tb/tb_bus_pack.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_pack.sv
// rtl/bus_pack.sv - packs NIN serial WIDTH-bit words into one beat, early close on in_last
// Accumulator holds the partial beat; a separate output register holds the completed one.
module bus_pack #(
    parameter int NIN   = 4,
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(NIN),
    localparam int NW   = $clog2(NIN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [NIN*WIDTH-1:0] out_data,
    output logic [NW-1:0]        out_nwords,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [CW-1:0]        r_cnt;
    logic [NIN*WIDTH-1:0] r_acc;
    logic [NIN*WIDTH-1:0] r_out_data;
    logic [NW-1:0]        r_out_nwords;
    logic                 r_out_last;
    logic                 r_out_valid;

    logic [NIN*WIDTH-1:0] w_beat;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_done;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_done     = w_accept && ((r_cnt == CW'(NIN - 1)) || in_last);

    // Slots above r_cnt are always zero because the accumulator is cleared on every completion.
    always_comb begin
        w_beat = r_acc;
        w_beat[int'(r_cnt)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_out_data   <= '0;
            r_out_nwords <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else if (w_done) begin
            r_out_data   <= w_beat;
            r_out_nwords <= NW'(r_cnt) + NW'(1);
            r_out_last   <= in_last;
            r_out_valid  <= 1'b1;
            r_cnt        <= '0;
            r_acc        <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= w_beat;
                r_cnt <= r_cnt + CW'(1);
            end
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_out_data;
    assign out_nwords = r_out_nwords;
    assign out_last   = r_out_last;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_bus_pack.sv
// tb/tb_bus_pack.sv - directed and random scoreboard bench for bus_pack (NIN=4, WIDTH=8)
module tb_bus_pack;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [2:0]  out_nwords;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    bus_pack #(.NIN(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_nwords(out_nwords),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  n;
        logic        l;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] m_acc;
    int          m_cnt;
    int          n_cmp;
    int          n_err;
    int          n_beats;
    logic [31:0] got_data;
    logic [2:0]  got_nw;
    logic        got_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard, advance the model.
    task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic r,
                       output logic accepted);
        logic  exp_vld;
        logic  exp_rdy;
        beat_t b;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        exp_vld = (sb.size() > 0);
        exp_rdy = !exp_vld || r;
        chk("out_valid", 64'(out_valid), 64'(exp_vld));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_vld) begin
            b = sb[0];
            chk("out_data", 64'(out_data), 64'(b.d));
            chk("out_nwords", 64'(out_nwords), 64'(b.n));
            chk("out_last", 64'(out_last), 64'(b.l));
            if (r) begin
                void'(sb.pop_front());
                got_data = out_data;
                got_nw   = out_nwords;
                got_last = out_last;
                n_beats++;
            end
        end
        accepted = v && exp_rdy;
        if (accepted) begin
            m_acc[m_cnt*8 +: 8] = d;
            if (m_cnt == 3 || l) begin
                b.d = m_acc;
                b.n = 3'(m_cnt + 1);
                b.l = l;
                sb.push_back(b);
                m_acc = '0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic r);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            cyc(1'b1, d, l, r, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, acc);
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_nwords", 64'(out_nwords), 64'(0));
        sb.delete();
        m_acc = '0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        acc;
        logic [7:0]  cur;
        logic        cl;
        int          words;
        int          cycles;

        n_cmp = 0; n_err = 0; n_beats = 0;
        m_acc = '0; m_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_data", 64'(out_data), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full beat, single-cycle out_valid
        send(8'h11, 1'b0, 1'b1); send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b1); send(8'h44, 1'b0, 1'b1);
        drain();
        chk("full_data", 64'(got_data), 64'h44332211);
        chk("full_nwords", 64'(got_nw), 64'(4));
        chk("full_last", 64'(got_last), 64'(0));

        // Early close, then no residue in the next beat
        send(8'hAA, 1'b0, 1'b1); send(8'hBB, 1'b1, 1'b1);
        drain();
        chk("early_data", 64'(got_data), 64'h0000BBAA);
        chk("early_nwords", 64'(got_nw), 64'(2));
        chk("early_last", 64'(got_last), 64'(1));
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b1);
        drain();
        chk("residue_data", 64'(got_data), 64'h04030201);

        // in_last on first word and on the last slot
        send(8'hC1, 1'b1, 1'b1);
        drain();
        chk("first_last_data", 64'(got_data), 64'h000000C1);
        chk("first_last_nw", 64'(got_nw), 64'(1));
        for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), (i == 3), 1'b1);
        drain();
        chk("slot_last_data", 64'(got_data), 64'hD3D2D1D0);
        chk("slot_last_nw", 64'(got_nw), 64'(4));
        chk("slot_last_last", 64'(got_last), 64'(1));

        // Continuous stream, one word per cycle
        n_beats = 0;
        for (int i = 1; i <= 12; i++) send(8'(i), 1'b0, 1'b1);
        drain();
        chk("stream_beats", 64'(n_beats), 64'(3));
        chk("stream_data", 64'(got_data), 64'h0C0B0A09);

        // Backpressure: pending beat held for 5 cycles, source holds its word
        for (int i = 0; i < 4; i++) send(8'h51 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h55, 1'b0, 1'b0, acc);
            chk("stall_accept", 64'(acc), 64'(0));
        end
        for (int i = 0; i < 4; i++) send(8'h55 + 8'(i), 1'b0, 1'b1);
        drain();
        chk("stall_after_data", 64'(got_data), 64'h58575655);

        // Reset with a beat pending
        for (int i = 0; i < 4; i++) send(8'h61 + 8'(i), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h71 + 8'(i), 1'b0, 1'b1);
        drain();
        chk("rst_pend_data", 64'(got_data), 64'h74737271);

        // Reset after 2 of 4 words
        send(8'h81, 1'b0, 1'b1); send(8'h82, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h91 + 8'(i), 1'b0, 1'b1);
        drain();
        chk("rst_part_data", 64'(got_data), 64'h94939291);
        chk("rst_part_nw", 64'(got_nw), 64'(4));

        // Random valid/ready/last
        words  = 0;
        cycles = 0;
        cur    = 8'($urandom);
        cl     = ($urandom_range(0, 4) == 0);
        while (words < 10000 && cycles < 40000) begin
            cyc(($urandom_range(0, 9) < 7), cur, cl, ($urandom_range(0, 9) < 7), acc);
            if (acc && in_valid) begin
                words++;
                cur = 8'($urandom);
                cl  = ($urandom_range(0, 4) == 0);
            end
            cycles++;
        end
        chk("rand_words", 64'(words), 64'(10000));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
